// File: rtl/approx_multiplier_sr.sv
// Approximate multiplier: leading-one segmenting, serial shift-add, rescale.
// Signed/unsigned, truncate/round segmenting, saturating output, fixed latency.
module approx_multiplier_sr #(
    parameter int N_IN  = 16,
    parameter int N_EFF = 8,
    parameter int N_OUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             signed_mode,
    input  logic             round_mode,
    input  logic [N_IN-1:0]  pin1,
    input  logic [N_IN-1:0]  pin2,
    output logic             Busy,
    output logic             Done,
    output logic [N_OUT-1:0] pout,
    output logic             ovf
);

    localparam int SW = $clog2(N_IN + 2);
    localparam int CW = $clog2(N_EFF + 1);
    localparam int AW = 2 * N_EFF;
    localparam int PW = 2 * N_IN + 1;
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW-1:0] UMAX = (ONE << N_OUT) - ONE;
    localparam logic [PW-1:0] SMAX = (ONE << (N_OUT - 1)) - ONE;
    localparam logic [PW-1:0] SMIN = ONE << (N_OUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, MUL, FIN} state_t;

    state_t           state;
    state_t           state_next;
    logic [N_IN-1:0]  a_q;
    logic [N_IN-1:0]  b_q;
    logic             sm_q;
    logic             rm_q;
    logic             neg_q;
    logic [AW-1:0]    mcand;
    logic [N_EFF-1:0] mplr;
    logic [AW-1:0]    acc;
    logic [SW-1:0]    sh1;
    logic [SW-1:0]    sh2;
    logic [CW-1:0]    cnt;

    logic [SW-1:0]    sh1_c;
    logic [SW-1:0]    sh2_c;
    logic [N_EFF-1:0] seg1_c;
    logic [N_EFF-1:0] seg2_c;
    logic [SW:0]      shamt;
    logic [PW-1:0]    prod;
    logic [N_OUT-1:0] neg_low;
    logic [N_OUT-1:0] sat_val;
    logic             sat_ovf;

    // |x| in signed mode; the most negative value maps to 2^(N_IN-1)
    function automatic logic [N_IN-1:0] magnitude(
        input logic [N_IN-1:0] x,
        input logic            sgn
    );
        return (sgn && x[N_IN-1]) ? -x : x;
    endfunction

    // Cut an N_EFF-bit segment at the leading one; returns {shift, segment}
    function automatic logic [SW+N_EFF-1:0] segment(
        input logic [N_IN-1:0] mag,
        input logic            rnd
    );
        logic [N_IN-1:0] sh;
        logic [N_EFF:0]  seg;
        logic [SW-1:0]   s;
        int              p;
        p = 0;
        for (int i = 0; i < N_IN; i++) begin
            if (mag[i]) p = i;
        end
        if (p >= N_EFF) s = SW'(p - N_EFF + 1);
        else s = '0;
        sh  = mag >> s;
        seg = {1'b0, sh[N_EFF-1:0]};
        if (rnd && s != '0) begin
            sh = mag >> (s - SW'(1));
            if (sh[0]) seg = seg + {{N_EFF{1'b0}}, 1'b1};
        end
        if (seg[N_EFF]) begin
            seg = '0;
            seg[N_EFF-1] = 1'b1;
            s = s + SW'(1);
        end
        return {s, seg[N_EFF-1:0]};
    endfunction

    assign Busy = (state != IDLE);

    // Segment both latched operands for the LOAD step
    always_comb begin
        {sh1_c, seg1_c} = segment(magnitude(a_q, sm_q), rm_q);
        {sh2_c, seg2_c} = segment(magnitude(b_q, sm_q), rm_q);
    end

    // Rescale the segment product, apply sign and clamp to the output range
    always_comb begin
        shamt   = {1'b0, sh1} + {1'b0, sh2};
        prod    = {{(PW - AW){1'b0}}, acc} << shamt;
        neg_low = -prod[N_OUT-1:0];
        sat_val = prod[N_OUT-1:0];
        sat_ovf = 1'b0;
        if (neg_q) begin
            if (prod > SMIN) begin
                sat_val = SMIN[N_OUT-1:0];
                sat_ovf = 1'b1;
            end else begin
                sat_val = neg_low;
            end
        end else if (sm_q) begin
            if (prod > SMAX) begin
                sat_val = SMAX[N_OUT-1:0];
                sat_ovf = 1'b1;
            end
        end else if (prod > UMAX) begin
            sat_val = UMAX[N_OUT-1:0];
            sat_ovf = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_next;
    end

    // Next-state logic: IDLE -> LOAD -> MUL x N_EFF -> FIN -> IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (Start) state_next = LOAD;
            LOAD: state_next = MUL;
            MUL:  if (cnt == CW'(N_EFF - 1)) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch, segment, shift-add, publish result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sm_q  <= 1'b0;
            rm_q  <= 1'b0;
            neg_q <= 1'b0;
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            sh1   <= '0;
            sh2   <= '0;
            cnt   <= '0;
            pout  <= '0;
            ovf   <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= (state == FIN);
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        a_q  <= pin1;
                        b_q  <= pin2;
                        sm_q <= signed_mode;
                        rm_q <= round_mode;
                    end
                end
                LOAD: begin
                    neg_q <= sm_q & (a_q[N_IN-1] ^ b_q[N_IN-1]);
                    mcand <= {{N_EFF{1'b0}}, seg1_c};
                    mplr  <= seg2_c;
                    sh1   <= sh1_c;
                    sh2   <= sh2_c;
                    acc   <= '0;
                    cnt   <= '0;
                end
                MUL: begin
                    if (mplr[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CW'(1);
                end
                FIN: begin
                    pout <= sat_val;
                    ovf  <= sat_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_multiplier_sr.sv
// Directed bench for approx_multiplier_sr: 32-bit and 16-bit output
// instances share stimulus; expected values are hand-computed.
module tb_approx_multiplier_sr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sm = 1'b0;
    logic        rm = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        busy32, done32, ovf32;
    logic [31:0] pout32;
    logic        busy16, done16, ovf16;
    logic [15:0] pout16;

    int checks = 0;
    int errors = 0;
    int n, bz, dn;

    approx_multiplier_sr #(.N_IN(16), .N_EFF(8), .N_OUT(32)) u32 (
        .clk(clk), .rst(rst), .Start(start), .signed_mode(sm),
        .round_mode(rm), .pin1(a), .pin2(b), .Busy(busy32),
        .Done(done32), .pout(pout32), .ovf(ovf32)
    );

    approx_multiplier_sr #(.N_IN(16), .N_EFF(8), .N_OUT(16)) u16 (
        .clk(clk), .rst(rst), .Start(start), .signed_mode(sm),
        .round_mode(rm), .pin1(a), .pin2(b), .Busy(busy16),
        .Done(done16), .pout(pout16), .ovf(ovf16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Present a request for one edge, then scramble inputs
    task automatic launch(input logic smv, input logic rmv,
                          input logic [15:0] av, input logic [15:0] bv);
        sm = smv;
        rm = rmv;
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        sm = ~smv;
        rm = ~rmv;
    endtask

    // Count edges until Done, bounded; also count Busy cycles
    task automatic wait_done(output int edges, output int busy);
        edges = 0;
        busy = busy32 ? 1 : 0;
        while (!done32 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy32) busy++;
        end
        chk("done_seen", 64'(done32), 64'd1);
    endtask

    task automatic op(input string tag, input logic smv, input logic rmv,
                      input logic [15:0] av, input logic [15:0] bv,
                      input logic [31:0] e32, input logic o32,
                      input logic [15:0] e16, input logic o16);
        int e, bsy;
        launch(smv, rmv, av, bv);
        wait_done(e, bsy);
        chk({tag, "_lat"}, 64'(e), 64'd10);
        chk({tag, "_p32"}, 64'(pout32), 64'(e32));
        chk({tag, "_o32"}, 64'(ovf32), 64'(o32));
        chk({tag, "_d16"}, 64'(done16), 64'd1);
        chk({tag, "_p16"}, 64'(pout16), 64'(e16));
        chk({tag, "_o16"}, 64'(ovf16), 64'(o16));
    endtask

    initial begin
        #2 rst = 1'b0;
        #10;
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_pout", 64'(pout32), 64'd0);
        chk("rst_ovf", 64'(ovf32), 64'd0);
        chk("rst_pout16", 64'(pout16), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        launch(1'b0, 1'b0, 16'h0100, 16'h0100);
        wait_done(n, bz);
        chk("t1_lat", 64'(n), 64'd10);
        chk("t1_busy", 64'(bz), 64'd10);
        chk("t1_p32", 64'(pout32), 64'h0001_0000);
        chk("t1_o32", 64'(ovf32), 64'd0);
        chk("t1_p16", 64'(pout16), 64'hFFFF);
        chk("t1_o16", 64'(ovf16), 64'd1);
        @(posedge clk);
        #1;
        chk("t1_pulse", 64'(done32), 64'd0);
        chk("t1_hold", 64'(pout32), 64'h0001_0000);

        op("t2_trunc", 0, 0, 16'hD551, 16'hFFFF,
           32'hD42B_0000, 0, 16'hFFFF, 1);
        op("t2_round", 0, 1, 16'hD551, 16'hFFFF,
           32'hD500_0000, 0, 16'hFFFF, 1);
        op("t3_neg", 1, 0, 16'hFFFF, 16'h0003,
           32'hFFFF_FFFD, 0, 16'hFFFD, 0);
        op("t3_min", 1, 0, 16'h8000, 16'h8000,
           32'h4000_0000, 0, 16'h7FFF, 1);
        op("t4_negsat", 1, 0, 16'h8000, 16'h7FFF,
           32'hC040_0000, 0, 16'h8000, 1);
        op("exact", 0, 1, 16'h00FF, 16'h00FF,
           32'h0000_FE01, 0, 16'hFE01, 0);
        op("sround", 1, 1, 16'hFF00, 16'h0081,
           32'hFFFF_7F00, 0, 16'h8000, 1);
        op("zero", 0, 0, 16'h0000, 16'hFFFF,
           32'h0, 0, 16'h0, 0);

        sm = 1'b0;
        rm = 1'b0;
        a = 16'd3;
        b = 16'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(n, bz);
        start = 1'b0;
        chk("held_lat", 64'(n), 64'd10);
        chk("held_p32", 64'(pout32), 64'd15);
        dn = 0;
        bz = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done32) dn++;
            if (busy32) bz++;
        end
        chk("held_dones", 64'(dn), 64'd0);
        chk("held_busy", 64'(bz), 64'd0);

        launch(1'b0, 1'b0, 16'd3, 16'd5);
        wait_done(n, bz);
        chk("b2b1_p32", 64'(pout32), 64'd15);
        launch(1'b0, 1'b0, 16'h0100, 16'h0100);
        chk("b2b_busy", 64'(busy32), 64'd1);
        chk("b2b_hold", 64'(pout32), 64'd15);
        wait_done(n, bz);
        chk("b2b2_lat", 64'(n), 64'd10);
        chk("b2b2_p32", 64'(pout32), 64'h0001_0000);
        chk("b2b2_o16", 64'(ovf16), 64'd1);

        launch(1'b1, 1'b0, 16'h8000, 16'h8000);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_busy", 64'(busy32), 64'd0);
        chk("mid_done", 64'(done32), 64'd0);
        chk("mid_p32", 64'(pout32), 64'd0);
        chk("mid_o32", 64'(ovf32), 64'd0);
        chk("mid_p16", 64'(pout16), 64'd0);
        chk("mid_o16", 64'(ovf16), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        op("post_rst", 0, 1, 16'hD551, 16'hFFFF,
           32'hD500_0000, 0, 16'hFFFF, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
